// File: rtl/gate_bist_pkg.sv
// Shared encodings for the 2-input gate self-test engine: FSM states and reference truth tables.
// Truth-table bit i holds the expected gate output for input vector {a,b} == i.
package gate_bist_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_bist_checker_settle_timer.sv
// Settle timer: 8-bit up counter with synchronous clear and a terminal-count flag at
// SETTLE_CYCLES-1, used to hold each stimulus vector steady before the output is sampled.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == 8'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gate_bist_checker.sv
// Self-test engine for a 2-input gate: walks the four input vectors, lets each settle, samples y
// and compares it with TRUTH_TABLE, reporting pass, a saturating error count and per-vector flags.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE   = 4'b1110,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_vec
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       fail_vec_q, fail_vec_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             timer_clr, timer_en, timer_tc;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tc_o  (timer_tc)
  );

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    err_cnt_d  = err_cnt_q;
    fail_vec_d = fail_vec_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    timer_clr  = 1'b0;
    timer_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StDrive;
          vec_d      = 2'd0;
          err_cnt_d  = '0;
          fail_vec_d = '0;
          pass_d     = 1'b0;
          timer_clr  = 1'b1;
        end
      end
      StDrive: begin
        if (timer_tc) begin
          state_d = StCheck;
        end else begin
          timer_en = 1'b1;
        end
      end
      StCheck: begin
        timer_clr = 1'b1;
        // y comes straight from the gate in this clock domain; no synchroniser on purpose.
        if (y != TRUTH_TABLE[vec_q]) begin
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
          fail_vec_d[vec_q] = 1'b1;
        end
        if (vec_q == 2'd3) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end else begin
          vec_d   = vec_q + 2'd1;
          state_d = StDrive;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d == StDrive) || (state_d == StCheck);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      vec_q      <= 2'd0;
      err_cnt_q  <= '0;
      fail_vec_q <= '0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      err_cnt_q  <= err_cnt_d;
      fail_vec_q <= fail_vec_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign a        = vec_q[1];
  assign b        = vec_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign fail_vec = fail_vec_q;

endmodule
